// File: rtl/pipe_reg_skid_pkg.sv
// Shared definitions for the skid-buffered pipeline stage register.
// The state encoding equals the word count presented on the `count` port,
// so pipeline-control logic can compare `count` directly against these names.
package pipe_reg_skid_pkg;

    typedef enum logic [1:0] {
        PRS_EMPTY = 2'd0,   // nothing held
        PRS_FULL  = 2'd1,   // main valid
        PRS_SKID  = 2'd2    // main and skid valid
    } prs_state_e;

    localparam int unsigned PRS_CNT_W = 2;

endpackage

// File: rtl/pipe_reg_skid.sv
// Pipeline stage register with a one-entry skid buffer. in_ready depends only
// on the registered state, so there is no combinational path from out_ready
// back upstream. Flush discards everything and has priority over handshakes.
module pipe_reg_skid
    import pipe_reg_skid_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    input  logic                 flush,
    output logic [PRS_CNT_W-1:0] count
);

    prs_state_e       state_q, state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    logic in_fire;
    logic out_fire;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    assign in_fire  = in_valid  & in_ready;
    assign out_fire = out_valid & out_ready;

    // main takes the new word when it is the only slot (EMPTY) or is being
    // drained in the same cycle; in SKID no in_fire is possible.
    assign load_main_in   = in_fire & ((state_q == PRS_EMPTY) | out_fire);
    assign load_main_skid = (state_q == PRS_SKID) & out_fire;
    assign load_skid      = in_fire & (state_q == PRS_FULL) & ~out_fire;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= PRS_EMPTY;
        else        state_q <= state_d;
    end

    // Next-state logic; flush wins over any handshake
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = PRS_EMPTY;
        end else begin
            case (state_q)
                PRS_EMPTY: if (in_fire) state_d = PRS_FULL;
                PRS_FULL: begin
                    if (in_fire && !out_fire)      state_d = PRS_SKID;
                    else if (!in_fire && out_fire) state_d = PRS_EMPTY;
                end
                PRS_SKID:  if (out_fire) state_d = PRS_FULL;
                default:   state_d = PRS_EMPTY;
            endcase
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        in_ready  = (state_q != PRS_SKID);
        out_valid = (state_q != PRS_EMPTY);
        count     = state_q;
        out_data  = main_q;
    end

    // main register: front of the queue, drives out_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              main_q <= RESET_VAL;
        else if (flush)          main_q <= RESET_VAL;
        else if (load_main_in)   main_q <= in_data;
        else if (load_main_skid) main_q <= skid_q;
    end

    // skid register: catches the word accepted while main is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         skid_q <= RESET_VAL;
        else if (flush)     skid_q <= RESET_VAL;
        else if (load_skid) skid_q <= in_data;
    end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid: directed vector table on a 32-bit instance, an
// async-reset sequence, then random traffic on 8- and 64-bit instances
// against a queue model.
module tb_pipe_reg_skid;

    localparam logic [31:0] RV32 = 32'hDEAD_BEEF;
    localparam logic [7:0]  RV8  = 8'h5A;
    localparam logic [63:0] RV64 = 64'h0123_4567_89AB_CDEF;

    logic clk, rst_n;

    logic v32, r32, f32, ir32, ov32;
    logic [31:0] d32, od32;
    logic [1:0]  c32;

    logic v8, r8, f8, ir8, ov8;
    logic [7:0] d8, od8;
    logic [1:0] c8;

    logic v64, r64, f64, ir64, ov64;
    logic [63:0] d64, od64;
    logic [1:0]  c64;

    int n_cmp = 0;
    int n_err = 0;

    pipe_reg_skid #(.WIDTH(32), .RESET_VAL(RV32)) u_d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_data(d32), .in_ready(ir32),
        .out_valid(ov32), .out_data(od32), .out_ready(r32), .flush(f32), .count(c32));

    pipe_reg_skid #(.WIDTH(8), .RESET_VAL(RV8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_data(d8), .in_ready(ir8),
        .out_valid(ov8), .out_data(od8), .out_ready(r8), .flush(f8), .count(c8));

    pipe_reg_skid #(.WIDTH(64), .RESET_VAL(RV64)) u_d64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_data(d64), .in_ready(ir64),
        .out_valid(ov64), .out_data(od64), .out_ready(r64), .flush(f64), .count(c64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_ir;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic iv, logic [31:0] id, logic ordy, logic fl,
                                logic e_ov, logic [31:0] e_od, logic e_ir, logic [1:0] e_cnt);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
        v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [7:0]  q8[$];
    logic [63:0] q64[$];
    logic hold8, hold64, acc;

    initial begin
        // Expected values are the DUT outputs after the edge that applies the row.
        // streaming, out_ready=1
        tbl.push_back(mk(1, 32'h11, 1, 0,  1, 32'h11, 1, 1));
        tbl.push_back(mk(1, 32'h22, 1, 0,  1, 32'h22, 1, 1));
        tbl.push_back(mk(1, 32'h33, 1, 0,  1, 32'h33, 1, 1));
        tbl.push_back(mk(0, 32'h0,  1, 0,  0, 32'h33, 1, 0));
        // backpressure: A, B accepted, C held until room
        tbl.push_back(mk(1, 32'hA,  0, 0,  1, 32'hA,  1, 1));
        tbl.push_back(mk(1, 32'hB,  0, 0,  1, 32'hA,  0, 2));
        tbl.push_back(mk(1, 32'hC,  0, 0,  1, 32'hA,  0, 2));
        tbl.push_back(mk(1, 32'hC,  1, 0,  1, 32'hB,  1, 1));
        tbl.push_back(mk(1, 32'hC,  1, 0,  1, 32'hC,  1, 1));
        tbl.push_back(mk(0, 32'h0,  1, 0,  0, 32'hC,  1, 0));
        // flush in SKID with a word offered: D dropped
        tbl.push_back(mk(1, 32'h1,  0, 0,  1, 32'h1,  1, 1));
        tbl.push_back(mk(1, 32'h2,  0, 0,  1, 32'h1,  0, 2));
        tbl.push_back(mk(1, 32'hD,  0, 1,  0, RV32,   1, 0));
        tbl.push_back(mk(0, 32'h0,  1, 0,  0, RV32,   1, 0));
        // simultaneous accept and consume in FULL, then flush in FULL
        tbl.push_back(mk(1, 32'h5,  0, 0,  1, 32'h5,  1, 1));
        tbl.push_back(mk(1, 32'h6,  1, 0,  1, 32'h6,  1, 1));
        tbl.push_back(mk(1, 32'h7,  1, 1,  0, RV32,   1, 0));
        // acceptance right after flush, long stall, drain
        tbl.push_back(mk(1, 32'h8,  0, 0,  1, 32'h8,  1, 1));
        tbl.push_back(mk(1, 32'h9,  0, 0,  1, 32'h8,  0, 2));
        tbl.push_back(mk(0, 32'h0,  0, 0,  1, 32'h8,  0, 2));
        tbl.push_back(mk(0, 32'h0,  1, 0,  1, 32'h9,  1, 1));
        tbl.push_back(mk(0, 32'h0,  1, 0,  0, 32'h9,  1, 0));

        rst_n = 1'b0;
        v32 = 0; d32 = '0; r32 = 0; f32 = 0;
        v8  = 0; d8  = '0; r8  = 0; f8  = 0;
        v64 = 0; d64 = '0; r64 = 0; f64 = 0;
        hold8 = 0; hold64 = 0; acc = 0;

        repeat (2) @(negedge clk);
        chk("rst_ov",  64'(ov32), 64'(1'b0));
        chk("rst_ir",  64'(ir32), 64'(1'b1));
        chk("rst_cnt", 64'(c32),  64'(2'd0));
        chk("rst_od",  64'(od32), 64'(RV32));
        rst_n = 1'b1;

        // directed table
        for (int i = 0; i < tbl.size(); i++) begin
            v32 = tbl[i].iv; d32 = tbl[i].id; r32 = tbl[i].ordy; f32 = tbl[i].fl;
            @(posedge clk); #1;
            chk($sformatf("row%0d_ov", i),  64'(ov32), 64'(tbl[i].e_ov));
            chk($sformatf("row%0d_od", i),  64'(od32), 64'(tbl[i].e_od));
            chk($sformatf("row%0d_ir", i),  64'(ir32), 64'(tbl[i].e_ir));
            chk($sformatf("row%0d_cnt", i), 64'(c32),  64'(tbl[i].e_cnt));
            @(negedge clk);
        end

        // async reset while two words are held
        v32 = 1; d32 = 32'hE1; r32 = 0; f32 = 0;
        @(posedge clk); #1;
        @(negedge clk);
        d32 = 32'hE2;
        @(posedge clk); #1;
        chk("ar_cnt_pre", 64'(c32), 64'(2'd2));
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ov",  64'(ov32), 64'(1'b0));
        chk("ar_cnt", 64'(c32),  64'(2'd0));
        chk("ar_ir",  64'(ir32), 64'(1'b1));
        chk("ar_od",  64'(od32), 64'(RV32));
        @(negedge clk);
        rst_n = 1'b1;
        d32 = 32'hF1;
        @(posedge clk); #1;
        chk("ar_first_ov",  64'(ov32), 64'(1'b1));
        chk("ar_first_od",  64'(od32), 64'(32'hF1));
        chk("ar_first_cnt", 64'(c32),  64'(2'd1));
        @(negedge clk);
        v32 = 0; r32 = 1;

        // random traffic against a queue model, 8- and 64-bit
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            chk("r8_ov",  64'(ov8), 64'(q8.size() != 0));
            chk("r8_ir",  64'(ir8), 64'(q8.size() < 2));
            chk("r8_cnt", 64'(c8),  64'(q8.size()));
            if (q8.size() != 0) chk("r8_od", 64'(od8), 64'(q8[0]));
            chk("r64_ov",  64'(ov64), 64'(q64.size() != 0));
            chk("r64_ir",  64'(ir64), 64'(q64.size() < 2));
            chk("r64_cnt", 64'(c64),  64'(q64.size()));
            if (q64.size() != 0) chk("r64_od", od64, q64[0]);

            if (!hold8) begin
                v8 = ($urandom_range(0, 3) != 0);
                d8 = 8'($urandom);
            end
            r8 = ($urandom_range(0, 2) != 0);
            f8 = ($urandom_range(0, 63) == 0);
            acc   = v8 && (q8.size() < 2) && !f8;
            hold8 = v8 && !acc && !f8;
            if (f8) q8.delete();
            else begin
                if (q8.size() != 0 && r8) void'(q8.pop_front());
                if (acc) q8.push_back(d8);
            end

            if (!hold64) begin
                v64 = ($urandom_range(0, 1) != 0);
                d64 = {$urandom, $urandom};
            end
            r64 = ($urandom_range(0, 1) != 0);
            f64 = ($urandom_range(0, 63) == 0);
            acc    = v64 && (q64.size() < 2) && !f64;
            hold64 = v64 && !acc && !f64;
            if (f64) q64.delete();
            else begin
                if (q64.size() != 0 && r64) void'(q64.pop_front());
                if (acc) q64.push_back(d64);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
